ram_uart_streamer: RTL and testbench



---
 rtl/uart_stream_pkg.sv | 27 ++
 rtl/ram_uart_streamer_if.sv | 27 ++
 rtl/ram_uart_streamer.sv | 162 ++++++++++++++++
 tb/tb_ram_uart_streamer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stream_pkg.sv
// Shared constants for the capture-RAM to UART frame streamer.
// Checksum option is selected by RAM_UART_STREAMER_CHKSUM_EN.
package uart_stream_pkg;

    localparam logic [7:0] SOF_CHK   = 8'hA5;
    localparam logic [7:0] SOF_NOCHK = 8'hA4;

`ifdef RAM_UART_STREAMER_CHKSUM_EN
    localparam logic [7:0] SOF_BYTE  = SOF_CHK;
`else
    localparam logic [7:0] SOF_BYTE  = SOF_NOCHK;
`endif

    // SOF + two length bytes precede the payload
    localparam int HDR_BYTES = 3;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_SOF   = 4'd1;
    localparam logic [3:0] ST_LEN_H = 4'd2;
    localparam logic [3:0] ST_LEN_L = 4'd3;
    localparam logic [3:0] ST_FETCH = 4'd4;
    localparam logic [3:0] ST_WAIT  = 4'd5;
    localparam logic [3:0] ST_SEND  = 4'd6;
    localparam logic [3:0] ST_CHK   = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

endpackage

// File: rtl/ram_uart_streamer_if.sv
// Control, RAM port-B and UART TX byte signals of the frame streamer.
interface ram_uart_streamer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   len;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, len, ram_dout, tx_ready,
        output ram_en, ram_addr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, abort, len, ram_dout, tx_ready,
        input  ram_en, ram_addr, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/ram_uart_streamer.sv
// Reads a run of bytes from the capture RAM and sends SOF, 16-bit length, payload
// and (with RAM_UART_STREAMER_CHKSUM_EN defined) an XOR checksum to the UART TX.
module ram_uart_streamer
    import uart_stream_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic clk200,
    input  logic rst,
    ram_uart_streamer_if.master bus
);

    logic [3:0]        state_reg;
    logic [ADDR_W:0]   remaining_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] tx_data_reg;
    logic              tx_valid_reg;
    logic              ram_en_reg;
    logic              busy_reg;
    logic              done_reg;
`ifdef RAM_UART_STREAMER_CHKSUM_EN
    logic [DATA_W-1:0] chk_reg;
`endif

    logic        handshake;
    logic [15:0] len16;

    assign handshake = tx_valid_reg & bus.tx_ready;
    // remaining_reg still holds the full length while the header is going out
    assign len16     = 16'(remaining_reg);

    always_ff @(posedge clk200 or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            addr_reg      <= '0;
            tx_data_reg   <= '0;
            tx_valid_reg  <= 1'b0;
            ram_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef RAM_UART_STREAMER_CHKSUM_EN
            chk_reg       <= '0;
`endif
        end else if (bus.abort) begin
            state_reg    <= ST_IDLE;
            tx_valid_reg <= 1'b0;
            ram_en_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            ram_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg     <= ST_SOF;
                        remaining_reg <= bus.len;
                        addr_reg      <= '0;
                        tx_data_reg   <= SOF_BYTE;
                        tx_valid_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
`ifdef RAM_UART_STREAMER_CHKSUM_EN
                        chk_reg       <= '0;
`endif
                    end
                end
                ST_SOF: begin
                    if (handshake) begin
                        state_reg   <= ST_LEN_H;
                        tx_data_reg <= len16[15:8];
                    end
                end
                ST_LEN_H: begin
                    if (handshake) begin
                        state_reg   <= ST_LEN_L;
                        tx_data_reg <= len16[7:0];
                    end
                end
                ST_LEN_L: begin
                    if (handshake) begin
                        if (remaining_reg == '0) begin
`ifdef RAM_UART_STREAMER_CHKSUM_EN
                            state_reg    <= ST_CHK;
                            tx_data_reg  <= chk_reg;
`else
                            state_reg    <= ST_DONE;
                            tx_valid_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
`endif
                        end else begin
                            state_reg    <= ST_FETCH;
                            tx_valid_reg <= 1'b0;
                            ram_en_reg   <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_reg    <= ST_SEND;
                    tx_data_reg  <= bus.ram_dout;
                    tx_valid_reg <= 1'b1;
                end
                ST_SEND: begin
                    if (handshake) begin
                        remaining_reg <= remaining_reg - 1'b1;
`ifdef RAM_UART_STREAMER_CHKSUM_EN
                        chk_reg       <= chk_reg ^ tx_data_reg;
`endif
                        if (remaining_reg == 1) begin
`ifdef RAM_UART_STREAMER_CHKSUM_EN
                            state_reg    <= ST_CHK;
                            tx_data_reg  <= chk_reg ^ tx_data_reg;
`else
                            state_reg    <= ST_DONE;
                            tx_valid_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
`endif
                        end else begin
                            // address only advances when another byte follows
                            addr_reg     <= addr_reg + 1'b1;
                            state_reg    <= ST_FETCH;
                            tx_valid_reg <= 1'b0;
                            ram_en_reg   <= 1'b1;
                        end
                    end
                end
`ifdef RAM_UART_STREAMER_CHKSUM_EN
                ST_CHK: begin
                    if (handshake) begin
                        state_reg    <= ST_DONE;
                        tx_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    tx_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_en   = ram_en_reg;
    assign bus.ram_addr = addr_reg;
    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_valid = tx_valid_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_ram_uart_streamer.sv
// Directed bench for ram_uart_streamer; expectations follow RAM_UART_STREAMER_CHKSUM_EN.
`timescale 1ns/1ps
module tb_ram_uart_streamer;

    localparam int ADDR_W = 10;
`ifdef RAM_UART_STREAMER_CHKSUM_EN
    localparam logic [7:0] EXP_SOF = 8'hA5;
`else
    localparam logic [7:0] EXP_SOF = 8'hA4;
`endif

    logic clk200 = 1'b0;
    logic rst    = 1'b0;
    always #5 clk200 = ~clk200;

    ram_uart_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(8)) bus ();

    ram_uart_streamer #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
        .clk200 (clk200),
        .rst    (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Capture RAM port B: registered read
    logic [7:0] ram_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk200) begin
        if (bus.ram_en) bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    // Monitor sampled on the falling edge
    logic [7:0] tx_q [$];
    int         addr_q [$];
    int         done_cnt  = 0;
    int         stall_err = 0;
    int         drop_err  = 0;
    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk200) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                if (!bus.tx_valid) drop_err++;
                else if (bus.tx_data !== prev_data) stall_err++;
            end
            prev_stall <= bus.tx_valid && !bus.tx_ready;
            prev_data  <= bus.tx_data;
            prev_abort <= bus.abort;
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
            if (bus.ram_en) addr_q.push_back(int'(bus.ram_addr));
            if (bus.done) done_cnt++;
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic clear_logs();
        tx_q.delete();
        addr_q.delete();
        done_cnt  = 0;
        stall_err = 0;
        drop_err  = 0;
    endtask

    task automatic load_ram_small();
        for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = 8'h00;
        ram_mem[0] = 8'h11; ram_mem[1] = 8'h22; ram_mem[2] = 8'h33; ram_mem[3] = 8'h44;
    endtask

    // Sends one frame; stall_pct is the percentage of cycles with tx_ready low
    task automatic run_frame(input int n, input int stall_pct, input int budget,
                             output bit timed_out, output logic hdr_valid,
                             output logic [7:0] hdr_byte);
        timed_out = 1'b1;
        @(posedge clk200); #1;
        clear_logs();
        bus.len      = n[ADDR_W:0];
        bus.start    = 1'b1;
        bus.tx_ready = 1'b1;
        @(posedge clk200); #1;
        bus.start = 1'b0;
        hdr_valid = bus.tx_valid;
        hdr_byte  = bus.tx_data;
        for (int c = 0; c < budget; c++) begin
            bus.tx_ready = ($urandom_range(0, 99) >= stall_pct);
            @(posedge clk200); #1;
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk200);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.len = '0; bus.tx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk200);
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b want 0", bus.ram_en); end
        checks++; if (bus.ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %0d want 0", bus.ram_addr); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (2) @(posedge clk200);
        #1;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        bit to; logic hv; logic [7:0] hb;
        logic [7:0] exp [$];
`ifdef RAM_UART_STREAMER_CHKSUM_EN
        exp = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
`else
        exp = '{8'hA4, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
        load_ram_small();
        run_frame(4, 0, 200, to, hv, hb);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
        checks++; if (hv !== 1'b1 || hb !== EXP_SOF) begin errors++; $display("FAIL basic_hdr_latency got valid=%b data=%h want 1 %h", hv, hb, EXP_SOF); end
        checks++;
        if (tx_q.size() != exp.size()) begin
            errors++; $display("FAIL basic_len got %0d bytes want %0d", tx_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", bus.busy); end
        $display("test_basic: %0d bytes, %0d done", tx_q.size(), done_cnt);
    endtask

    task automatic test_backpressure();
        bit to; logic hv; logic [7:0] hb;
        logic [7:0] exp [$];
`ifdef RAM_UART_STREAMER_CHKSUM_EN
        exp = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
`else
        exp = '{8'hA4, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
        load_ram_small();
        run_frame(4, 30, 400, to, hv, hb);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got no done want done"); end
        checks++;
        if (tx_q.size() != exp.size()) begin
            errors++; $display("FAIL bp_len got %0d bytes want %0d", tx_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
        checks++; if (drop_err != 0) begin errors++; $display("FAIL bp_valid_drop got %0d drops want 0", drop_err); end
        checks++;
        if (addr_q.size() != 4) begin
            errors++; $display("FAIL bp_addr_count got %0d want 4", addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_q[i] != i) begin errors++; $display("FAIL bp_addr%0d got %0d want %0d", i, addr_q[i], i); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
        $display("test_backpressure: %0d bytes, %0d reads", tx_q.size(), addr_q.size());
    endtask

    task automatic test_len0();
        bit to; logic hv; logic [7:0] hb;
        logic [7:0] exp [$];
`ifdef RAM_UART_STREAMER_CHKSUM_EN
        exp = '{8'hA5, 8'h00, 8'h00, 8'h00};
`else
        exp = '{8'hA4, 8'h00, 8'h00};
`endif
        run_frame(0, 0, 100, to, hv, hb);
        checks++; if (to) begin errors++; $display("FAIL len0_timeout got no done want done"); end
        checks++;
        if (tx_q.size() != exp.size()) begin
            errors++; $display("FAIL len0_len got %0d bytes want %0d", tx_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp[i]) begin errors++; $display("FAIL len0_byte%0d got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL len0_ram_en got %0d reads want 0", addr_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL len0_done got %0d want 1", done_cnt); end
        $display("test_len0: %0d bytes", tx_q.size());
    endtask

    task automatic test_abort();
        bit to; bit reached; logic hv; logic [7:0] hb;
        logic [7:0] exp [$];
`ifdef RAM_UART_STREAMER_CHKSUM_EN
        exp = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
`else
        exp = '{8'hA4, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
        load_ram_small();
        @(posedge clk200); #1;
        clear_logs();
        bus.len = 11'd4; bus.start = 1'b1; bus.tx_ready = 1'b1;
        @(posedge clk200); #1;
        bus.start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tx_q.size() >= 5) begin reached = 1'b1; break; end
            @(posedge clk200); #1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL abort_wait got %0d bytes want 5", tx_q.size()); end
        bus.abort = 1'b1;
        @(posedge clk200); #1;
        bus.abort = 1'b0;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid got %b want 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL abort_ram_en got %b want 0", bus.ram_en); end
        repeat (6) @(posedge clk200);
        #1;
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        checks++; if (tx_q.size() != 5) begin errors++; $display("FAIL abort_no_more_bytes got %0d want 5", tx_q.size()); end

        run_frame(4, 0, 200, to, hv, hb);
        checks++; if (to) begin errors++; $display("FAIL abort_resend_timeout got no done want done"); end
        checks++;
        if (tx_q.size() != exp.size()) begin
            errors++; $display("FAIL abort_resend_len got %0d want %0d", tx_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp[i]) begin errors++; $display("FAIL abort_resend_byte%0d got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        checks++;
        if (addr_q.size() == 0 || addr_q[0] != 0) begin
            errors++; $display("FAIL abort_resend_addr0 got %0d reads first=%0d want first 0", addr_q.size(), (addr_q.size() == 0) ? -1 : addr_q[0]);
        end
        $display("test_abort: resend %0d bytes", tx_q.size());
    endtask

    task automatic test_start_rst();
        bit to; bit reached; logic hv; logic [7:0] hb;
        logic [7:0] exp [$];
`ifdef RAM_UART_STREAMER_CHKSUM_EN
        exp = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
`else
        exp = '{8'hA4, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
        load_ram_small();
        @(posedge clk200); #1;
        clear_logs();
        bus.len = 11'd4; bus.start = 1'b1; bus.tx_ready = 1'b1;
        @(posedge clk200); #1;
        bus.start = 1'b0;
        @(posedge clk200); #1;
        bus.start = 1'b1;
        bus.len   = 11'd2;
        @(posedge clk200); #1;
        bus.start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tx_q.size() >= 4) begin reached = 1'b1; break; end
            @(posedge clk200); #1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL srst_wait got %0d bytes want 4", tx_q.size()); end
        checks++;
        if (tx_q.size() < 4 || tx_q[0] !== EXP_SOF || tx_q[1] !== 8'h00 || tx_q[2] !== 8'h04 || tx_q[3] !== 8'h11) begin
            errors++; $display("FAIL second_start_ignored got %0d bytes first %h %h %h %h want %h 00 04 11",
                               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, (tx_q.size() > 1) ? tx_q[1] : 8'hxx,
                               (tx_q.size() > 2) ? tx_q[2] : 8'hxx, (tx_q.size() > 3) ? tx_q[3] : 8'hxx, EXP_SOF);
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", bus.tx_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b want 0", bus.ram_en); end
        checks++; if (bus.ram_addr !== '0) begin errors++; $display("FAIL rst_ram_addr got %0d want 0", bus.ram_addr); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", bus.tx_data); end
        repeat (2) @(posedge clk200);
        #1;
        rst = 1'b0;
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", done_cnt); end

        run_frame(4, 0, 200, to, hv, hb);
        checks++; if (to) begin errors++; $display("FAIL rst_restart_timeout got no done want done"); end
        checks++;
        if (tx_q.size() != exp.size()) begin
            errors++; $display("FAIL rst_restart_len got %0d want %0d", tx_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp[i]) begin errors++; $display("FAIL rst_restart_byte%0d got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        $display("test_start_rst: restart %0d bytes", tx_q.size());
    endtask

    task automatic test_full_length();
        bit to; logic hv; logic [7:0] hb;
        int bad_data;
        int bad_addr;
        int exp_total;
        logic [7:0] want;
        for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = 8'(i);
`ifdef RAM_UART_STREAMER_CHKSUM_EN
        exp_total = 3 + 1024 + 1;
`else
        exp_total = 3 + 1024;
`endif
        run_frame(1024, 0, 5000, to, hv, hb);
        checks++; if (to) begin errors++; $display("FAIL full_timeout got no done want done"); end
        checks++;
        if (tx_q.size() != exp_total) begin
            errors++; $display("FAIL full_len got %0d bytes want %0d", tx_q.size(), exp_total);
        end else begin
            checks++; if (tx_q[1] !== 8'h04 || tx_q[2] !== 8'h00) begin errors++; $display("FAIL full_len_bytes got %h %h want 04 00", tx_q[1], tx_q[2]); end
            bad_data = 0;
            for (int i = 0; i < 1024; i++) begin
                want = 8'(i);
                if (tx_q[3 + i] !== want) bad_data++;
            end
            checks++; if (bad_data != 0) begin errors++; $display("FAIL full_payload got %0d wrong bytes want 0", bad_data); end
`ifdef RAM_UART_STREAMER_CHKSUM_EN
            checks++; if (tx_q[exp_total - 1] !== 8'h00) begin errors++; $display("FAIL full_checksum got %h want 00", tx_q[exp_total - 1]); end
`endif
        end
        checks++;
        if (addr_q.size() != 1024) begin
            errors++; $display("FAIL full_addr_count got %0d want 1024", addr_q.size());
        end else begin
            bad_addr = 0;
            for (int i = 0; i < 1024; i++) if (addr_q[i] != i) bad_addr++;
            checks++; if (bad_addr != 0) begin errors++; $display("FAIL full_addr_seq got %0d wrong addresses want 0", bad_addr); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done got %0d want 1", done_cnt); end
        $display("test_full_length: %0d bytes, %0d reads", tx_q.size(), addr_q.size());
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.len      = '0;
        bus.tx_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
        test_abort();
        test_start_rst();
        test_full_length();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
